// File: rtl/xor_scrambler_pkg.sv
// Shared definitions for the XOR scrambler / descrambler pair.
// Holds the default polynomial and the tap-parity helper. The transmit-side
// scrambler uses the same helper, so both ends agree on tap semantics.
package xor_scrambler_pkg;

    // Default polynomial x^7 + x^6 + 1: TapMask bit k is a tap at delay k+1
    localparam int         LFSR_LEN_DEFAULT   = 7;
    localparam logic [6:0] TAP_MASK_DEFAULT   = 7'h60;
    localparam int         NR_OF_BITS_DEFAULT = 8;

    // Tap windows are carried at the widest legal polynomial degree
    localparam int TAP_WIN_W = 32;

    // Lock counter must hold NrOfBits + LfsrLength (at most 96) before it saturates
    localparam int LOCK_CNT_W = 7;

    typedef logic [TAP_WIN_W-1:0]  tap_win_t;
    typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

    // window[k] is the stream bit k+1 positions before the current one
    function automatic logic tap_parity(input tap_win_t window, input tap_win_t mask);
        return ^(window & mask);
    endfunction

endpackage

// File: rtl/xor_tap_network.sv
// Combinational unroll of the descramble rule over one word.
// The history bits and the current word are viewed as one continuous stream
// (history[0] oldest, data_in[NrOfBits-1] newest). Each output bit XORs its
// own input bit with the tapped earlier bits of that stream. The next history
// is the newest LfsrLength bits of the stream. This covers both
// NrOfBits < LfsrLength and NrOfBits >= LfsrLength.
module xor_tap_network
    import xor_scrambler_pkg::*;
#(
    parameter int                    NrOfBits   = NR_OF_BITS_DEFAULT,
    parameter int                    LfsrLength = LFSR_LEN_DEFAULT,
    parameter logic [LfsrLength-1:0] TapMask    = LfsrLength'(TAP_MASK_DEFAULT)
) (
    input  logic [LfsrLength-1:0] history,
    input  logic [NrOfBits-1:0]   data_in,
    output logic [NrOfBits-1:0]   data_out,
    output logic [LfsrLength-1:0] history_next
);

    localparam int       EXT_W    = NrOfBits + LfsrLength;
    localparam tap_win_t MASK_WIN = tap_win_t'(TapMask);

    logic [EXT_W-1:0] stream;

    // Oldest bits at the bottom, so stream[p-d] is the bit d positions before stream[p]
    assign stream       = {data_in, history};
    assign history_next = stream[EXT_W-1 -: LfsrLength];

    for (genvar i = 0; i < NrOfBits; i++) begin : g_bit
        tap_win_t window;

        for (genvar k = 0; k < TAP_WIN_W; k++) begin : g_win
            if (k < LfsrLength) begin : g_tap
                assign window[k] = stream[LfsrLength + i - k - 1];
            end else begin : g_pad
                assign window[k] = 1'b0;
            end
        end

        assign data_out[i] = stream[LfsrLength + i] ^ tap_parity(window, MASK_WIN);
    end

endmodule

// File: rtl/xor_descrambler.sv
// Self-synchronising parallel descrambler with a valid/ready handshake on both
// sides and one registered output stage. Each output word carries a lock
// flag. The flag is set once the history feeding that word came entirely from
// received bits and not from the zero fill after reset or Clear.
// Optional feature: define XOR_DESCRAMBLER_BYPASS_EN to add a Bypass input.
// Bypass passes accepted words through unchanged while history and lock
// tracking keep running.
module xor_descrambler
    import xor_scrambler_pkg::*;
#(
    parameter int                    NrOfBits   = NR_OF_BITS_DEFAULT,
    parameter int                    LfsrLength = LFSR_LEN_DEFAULT,
    parameter logic [LfsrLength-1:0] TapMask    = LfsrLength'(TAP_MASK_DEFAULT)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Clear,
    input  logic [NrOfBits-1:0] In_Data,
    input  logic                In_Valid,
`ifdef XOR_DESCRAMBLER_BYPASS_EN
    input  logic                Bypass,
`endif
    output logic                In_Ready,
    output logic [NrOfBits-1:0] Out_Data,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic                Out_Locked
);

    localparam lock_cnt_t LOCK_FULL     = lock_cnt_t'(LfsrLength);
    localparam lock_cnt_t BITS_PER_WORD = lock_cnt_t'(NrOfBits);

    logic [LfsrLength-1:0] history_q;
    logic [LfsrLength-1:0] history_next;
    logic [NrOfBits-1:0]   descrambled;
    logic [NrOfBits-1:0]   word_next;
    lock_cnt_t             lock_cnt_q;
    lock_cnt_t             lock_cnt_sum;
    lock_cnt_t             lock_cnt_next;
    logic                  accept;

    xor_tap_network #(
        .NrOfBits   (NrOfBits),
        .LfsrLength (LfsrLength),
        .TapMask    (TapMask)
    ) u_tap_network (
        .history      (history_q),
        .data_in      (In_Data),
        .data_out     (descrambled),
        .history_next (history_next)
    );

    // Clear blocks intake so a flushed cycle never also loads a word
    assign In_Ready = (~Out_Valid | Out_Ready) & ~Clear;
    assign accept   = In_Valid & In_Ready;

`ifdef XOR_DESCRAMBLER_BYPASS_EN
    assign word_next = Bypass ? In_Data : descrambled;
`else
    assign word_next = descrambled;
`endif

    // Count of received bits, saturating once the history is fully real
    assign lock_cnt_sum  = lock_cnt_q + BITS_PER_WORD;
    assign lock_cnt_next = (lock_cnt_sum >= LOCK_FULL) ? LOCK_FULL : lock_cnt_sum;

    // History and lock counter advance only on accepted words
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            history_q  <= '0;
            lock_cnt_q <= '0;
        end else if (Clear) begin
            history_q  <= '0;
            lock_cnt_q <= '0;
        end else if (accept) begin
            history_q  <= history_next;
            lock_cnt_q <= lock_cnt_next;
        end
    end

    // Output stage: load on accept, drop valid once consumed, hold while stalled
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Out_Data   <= '0;
            Out_Valid  <= 1'b0;
            Out_Locked <= 1'b0;
        end else if (Clear) begin
            Out_Data   <= '0;
            Out_Valid  <= 1'b0;
            Out_Locked <= 1'b0;
        end else if (accept) begin
            Out_Data   <= word_next;
            Out_Valid  <= 1'b1;
            Out_Locked <= (lock_cnt_q >= LOCK_FULL);
        end else if (Out_Ready) begin
            Out_Valid  <= 1'b0;
        end
    end

endmodule
